// File: rtl/tennis_court.sv
// One-dimensional tennis: a ball walks across COURT_LEN cells, players return it
// with swing edges, and the rally speeds up on every hit until someone reaches WIN_SCORE.
module tennis_court #(
  parameter int COURT_LEN    = 8,
  parameter int TICK_BITS    = 25,
  parameter int SPEEDUP_STEP = 50000,
  parameter int MIN_PERIOD   = 1 << 20,
  parameter int WIN_SCORE    = 7
) (
  input  logic                         CLK100MHZ,
  input  logic                         reset,
  input  logic                         swingLeft,
  input  logic                         swingRight,
  input  logic                         toss,
  output logic [$clog2(COURT_LEN)-1:0] ballPos,
  output logic                         ballVisible,
  output logic                         ballDir,
  output logic [3:0]                   scoreLeft,
  output logic [3:0]                   scoreRight,
  output logic                         server,
  output logic                         pointPulse,
  output logic                         gameOver
);

  localparam int POS_BITS = $clog2(COURT_LEN);
  localparam logic [POS_BITS-1:0]  LEFT_END    = '0;
  localparam logic [POS_BITS-1:0]  RIGHT_END   = POS_BITS'(COURT_LEN - 1);
  localparam logic [POS_BITS-1:0]  ONE_CELL    = POS_BITS'(1);
  localparam logic [TICK_BITS-1:0] FULL_PERIOD = '1;
  localparam logic [TICK_BITS-1:0] ONE_TICK    = TICK_BITS'(1);
  localparam logic [TICK_BITS:0]   STEP_W      = (TICK_BITS + 1)'(SPEEDUP_STEP);
  localparam logic [TICK_BITS:0]   FLOOR_W     = (TICK_BITS + 1)'(MIN_PERIOD);
  localparam logic [3:0]           WIN         = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    WAIT_SERVE,
    RALLY,
    GAME_OVER
  } stateType;

  stateType             state;
  logic [TICK_BITS-1:0] period;
  logic [TICK_BITS-1:0] tickCnt;
  logic [TICK_BITS-1:0] periodSped;
  logic [TICK_BITS:0]   periodWide;

  logic [2:0] rawIn;
  logic [2:0] edgeHit;
  logic       swingLeftEdge;
  logic       swingRightEdge;
  logic       tossEdge;

  assign rawIn = {toss, swingRight, swingLeft};

  // Each input gets a sample register plus a history register; an edge is "new high".
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gEdge
      logic syncReg;
      logic prevReg;
      always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
          syncReg <= 1'b0;
          prevReg <= 1'b0;
        end else begin
          syncReg <= rawIn[gi];
          prevReg <= syncReg;
        end
      end
      assign edgeHit[gi] = syncReg & ~prevReg;
    end
  endgenerate

  assign swingLeftEdge  = edgeHit[0];
  assign swingRightEdge = edgeHit[1];
  assign tossEdge       = edgeHit[2];

  logic       inRally;
  logic       moveTick;
  logic       receiverSwing;
  logic       atReceiverEnd;
  logic       hit;
  logic       award;
  logic [3:0] newLeft;
  logic [3:0] newRight;

  assign inRally       = (state == RALLY);
  assign moveTick      = inRally && (tickCnt <= ONE_TICK);
  assign receiverSwing = ballDir ? swingRightEdge : swingLeftEdge;
  assign atReceiverEnd = ballDir ? (ballPos == RIGHT_END) : (ballPos == LEFT_END);
  assign hit           = inRally && receiverSwing && atReceiverEnd;
  // A swing away from the end cell is a fault; a tick at the end cell is a miss.
  assign award         = inRally && ((receiverSwing && !atReceiverEnd) ||
                                     (moveTick && atReceiverEnd && !receiverSwing));
  assign newLeft       = scoreLeft + 4'd1;
  assign newRight      = scoreRight + 4'd1;

  // Speed-up saturates at the floor instead of wrapping below zero.
  always_comb begin
    periodWide = {1'b0, period};
    if (periodWide >= FLOOR_W + STEP_W) begin
      periodSped = TICK_BITS'(periodWide - STEP_W);
    end else begin
      periodSped = TICK_BITS'(FLOOR_W);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state       <= WAIT_SERVE;
      ballPos     <= LEFT_END;
      ballDir     <= 1'b1;
      server      <= 1'b0;
      scoreLeft   <= 4'd0;
      scoreRight  <= 4'd0;
      pointPulse  <= 1'b0;
      gameOver    <= 1'b0;
      ballVisible <= 1'b1;
      period      <= FULL_PERIOD;
      tickCnt     <= FULL_PERIOD;
    end else begin
      pointPulse <= 1'b0;
      unique case (state)
        WAIT_SERVE: begin
          if (tossEdge) begin
            state   <= RALLY;
            ballDir <= ~server;
            period  <= FULL_PERIOD;
            tickCnt <= FULL_PERIOD;
          end
        end
        RALLY: begin
          if (moveTick) begin
            tickCnt <= hit ? periodSped : period;
          end else begin
            tickCnt <= tickCnt - ONE_TICK;
          end
          if (hit) begin
            ballDir <= ~ballDir;
            period  <= periodSped;
            if (moveTick) begin
              ballPos <= ballDir ? (ballPos - ONE_CELL) : (ballPos + ONE_CELL);
            end
          end else if (award) begin
            pointPulse <= 1'b1;
            server     <= ~server;
            ballPos    <= server ? LEFT_END : RIGHT_END;
            state      <= WAIT_SERVE;
            // The receiver lost the point, so the winner sits opposite ballDir.
            if (ballDir) begin
              scoreLeft <= newLeft;
              if (newLeft == WIN) begin
                state       <= GAME_OVER;
                gameOver    <= 1'b1;
                ballVisible <= 1'b0;
              end
            end else begin
              scoreRight <= newRight;
              if (newRight == WIN) begin
                state       <= GAME_OVER;
                gameOver    <= 1'b1;
                ballVisible <= 1'b0;
              end
            end
          end else if (moveTick) begin
            ballPos <= ballDir ? (ballPos + ONE_CELL) : (ballPos - ONE_CELL);
          end
        end
        GAME_OVER: begin
          if (tossEdge) begin
            state       <= WAIT_SERVE;
            scoreLeft   <= 4'd0;
            scoreRight  <= 4'd0;
            server      <= 1'b0;
            ballPos     <= LEFT_END;
            gameOver    <= 1'b0;
            ballVisible <= 1'b1;
          end
        end
        default: state <= WAIT_SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_tennis_court.sv
// Directed bench for tennis_court with a short court and fast ticks so whole
// rallies, speed-ups, faults, misses and game over fit in a few thousand clocks.
module tb_tennis_court;

  logic       CLK100MHZ = 1'b0;
  logic       reset;
  logic       swingLeft;
  logic       swingRight;
  logic       toss;
  logic [2:0] ballPos;
  logic       ballVisible;
  logic       ballDir;
  logic [3:0] scoreLeft;
  logic [3:0] scoreRight;
  logic       server;
  logic       pointPulse;
  logic       gameOver;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  tennis_court #(
    .COURT_LEN   (8),
    .TICK_BITS   (4),
    .SPEEDUP_STEP(4),
    .MIN_PERIOD  (5),
    .WIN_SCORE   (3)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .reset      (reset),
    .swingLeft  (swingLeft),
    .swingRight (swingRight),
    .toss       (toss),
    .ballPos    (ballPos),
    .ballVisible(ballVisible),
    .ballDir    (ballDir),
    .scoreLeft  (scoreLeft),
    .scoreRight (scoreRight),
    .server     (server),
    .pointPulse (pointPulse),
    .gameOver   (gameOver)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input int got, input int exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("  ok   %-28s = %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK100MHZ);
      #1;
    end
  endtask

  // 0 = left swing, 1 = right swing, 2 = toss; high for exactly one sampling edge.
  task automatic pulse(input int which);
    case (which)
      0:       swingLeft  = 1'b1;
      1:       swingRight = 1'b1;
      default: toss       = 1'b1;
    endcase
    step(1);
    case (which)
      0:       swingLeft  = 1'b0;
      1:       swingRight = 1'b0;
      default: toss       = 1'b0;
    endcase
  endtask

  task automatic waitPos(input int p, output int at);
    int n = 0;
    while (int'(ballPos) != p && n < 400) begin
      step(1);
      n++;
    end
    if (int'(ballPos) != p) checkVal($sformatf("timeout waiting ballPos %0d", p), ballPos, p);
    at = cyc;
  endtask

  task automatic waitPulse(output int at);
    int n = 0;
    while (pointPulse !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    if (pointPulse !== 1'b1) checkVal("timeout waiting pointPulse", pointPulse, 1);
    at = cyc;
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, " ballPos"}, ballPos, 0);
    checkVal({tag, " ballDir"}, ballDir, 1);
    checkVal({tag, " server"}, server, 0);
    checkVal({tag, " scoreLeft"}, scoreLeft, 0);
    checkVal({tag, " scoreRight"}, scoreRight, 0);
    checkVal({tag, " pointPulse"}, pointPulse, 0);
    checkVal({tag, " gameOver"}, gameOver, 0);
    checkVal({tag, " ballVisible"}, ballVisible, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, t, prev;
    reset = 1'b1; swingLeft = 1'b0; swingRight = 1'b0; toss = 1'b0;
    step(3);
    checkReset("reset");
    reset = 1'b0;
    step(1);

    // Serve from the left, nobody swings: ball crosses, right misses.
    pulse(2); s = cyc;
    waitPos(1, t); checkVal("serve first move delay", t - s, 16); prev = t;
    for (int p = 2; p <= 7; p++) begin
      waitPos(p, t); checkVal($sformatf("serve step to %0d", p), t - prev, 15); prev = t;
    end
    waitPulse(t);  checkVal("miss delay at cell 7", t - prev, 15);
    checkVal("miss scoreLeft", scoreLeft, 1);
    checkVal("miss scoreRight", scoreRight, 0);
    checkVal("miss server", server, 1);
    checkVal("miss ballPos", ballPos, 7);
    checkVal("miss ballVisible", ballVisible, 1);
    step(1);
    checkVal("pointPulse one cycle", pointPulse, 0);

    // Right serves; non-receiver swing ignored; hits shorten the period 15,11,7,5,5.
    pulse(2); s = cyc;
    waitPos(6, t); checkVal("right serve first move", t - s, 16);
    waitPos(5, prev);
    pulse(1);
    waitPos(4, t); checkVal("non-receiver swing spacing", t - prev, 15);
    checkVal("non-receiver scoreRight", scoreRight, 0);
    checkVal("non-receiver ballDir", ballDir, 0);
    waitPos(0, prev);
    pulse(0); step(1);
    checkVal("left hit ballDir", ballDir, 1);
    checkVal("left hit ballPos", ballPos, 0);
    checkVal("left hit no point", pointPulse, 0);
    waitPos(1, t); checkVal("tick not reloaded on hit", t - prev, 15); prev = t;
    waitPos(2, t); checkVal("period after 1st hit", t - prev, 11);
    waitPos(7, t); pulse(1);
    waitPos(6, prev); waitPos(5, t); checkVal("period after 2nd hit", t - prev, 7);
    waitPos(0, t); swingLeft = 1'b1;
    waitPos(1, prev); waitPos(2, t); checkVal("period after 3rd hit", t - prev, 5);
    waitPos(7, t); pulse(1);
    waitPos(6, prev); waitPos(5, t); checkVal("period saturated", t - prev, 5);
    // swingLeft still held: no fresh edge, so the return is a miss.
    waitPos(0, prev); waitPulse(t);
    checkVal("held swing miss delay", t - prev, 5);
    checkVal("held swing scoreRight", scoreRight, 1);
    checkVal("held swing scoreLeft", scoreLeft, 1);
    checkVal("held swing server", server, 0);
    checkVal("held swing ballPos", ballPos, 0);
    swingLeft = 1'b0;
    step(2);

    // Fault: left swings while the ball is at cell 3 heading left.
    pulse(2);
    waitPos(7, t); pulse(1);
    waitPos(3, t); pulse(0); step(1);
    checkVal("fault pointPulse", pointPulse, 1);
    checkVal("fault scoreRight", scoreRight, 2);
    checkVal("fault scoreLeft", scoreLeft, 1);
    checkVal("fault server", server, 1);
    checkVal("fault ballPos", ballPos, 7);

    // Hit coinciding with the move tick at cell 7, then a miss ends the game.
    pulse(2);
    waitPos(0, t); pulse(0);
    waitPos(7, t);
    step(9);
    swingRight = 1'b1; step(1); swingRight = 1'b0;
    checkVal("before coincident tick pos", ballPos, 7);
    step(1);
    checkVal("coincident hit ballPos", ballPos, 6);
    checkVal("coincident hit ballDir", ballDir, 0);
    checkVal("coincident hit no point", pointPulse, 0);
    checkVal("coincident scoreRight", scoreRight, 2);
    waitPos(0, t); waitPulse(t);
    checkVal("final scoreRight", scoreRight, 3);
    checkVal("final scoreLeft", scoreLeft, 1);
    checkVal("gameOver set", gameOver, 1);
    checkVal("game over ballVisible", ballVisible, 0);

    // Game over ignores swings; toss starts a fresh game.
    pulse(0); pulse(1); step(20);
    checkVal("gameOver holds", gameOver, 1);
    checkVal("game over scoreLeft holds", scoreLeft, 1);
    checkVal("game over scoreRight holds", scoreRight, 3);
    pulse(2); step(1);
    checkVal("new game gameOver", gameOver, 0);
    checkVal("new game scoreLeft", scoreLeft, 0);
    checkVal("new game scoreRight", scoreRight, 0);
    checkVal("new game server", server, 0);
    checkVal("new game ballVisible", ballVisible, 1);
    checkVal("new game ballPos", ballPos, 0);

    // Toss ignored mid-rally; reset mid-rally restores everything including period.
    pulse(2);
    waitPos(2, prev); pulse(2);
    waitPos(3, t); checkVal("toss ignored in rally", t - prev, 15);
    waitPos(7, t); pulse(1);
    waitPos(5, t); checkVal("pre-reset ballDir", ballDir, 0);
    reset = 1'b1; step(1);
    checkReset("mid-rally reset");
    step(1); reset = 1'b0;
    pulse(2); s = cyc;
    waitPos(1, t); checkVal("post-reset first move", t - s, 16); prev = t;
    waitPos(2, t); checkVal("post-reset period", t - prev, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
